// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO feeding the register file write port, one retirement per cycle,
// with two combinational forwarding lookups over every result not yet written into the RF.
module rf_writeback_queue #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_addr,
    input  logic [N-1:0]               in_data,

    input  logic                       hold,

    output logic                       rf_we,
    output logic [2:0]                 rf_waddr,
    output logic [N-1:0]               rf_wdata,

    input  logic [2:0]                 lk_addr1,
    output logic                       lk_hit1,
    output logic [N-1:0]               lk_data1,
    input  logic [2:0]                 lk_addr2,
    output logic                       lk_hit2,
    output logic [N-1:0]               lk_data2,

    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [2:0]    mem_addr [DEPTH];
    logic [N-1:0]  mem_data [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          rf_we_q, rf_we_d;
    logic [2:0]    rf_waddr_q, rf_waddr_d;
    logic [N-1:0]  rf_wdata_q, rf_wdata_d;

    logic          push;
    logic          pop;

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !hold;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rf_we_d    = 1'b1;
            rf_waddr_d = mem_addr[rd_ptr_q];
            rf_wdata_d = mem_data[rd_ptr_q];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Storage needs no reset: an entry is only ever read while count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= in_addr;
            mem_data[wr_ptr_q] <= in_data;
        end
    end

    // Scan oldest to youngest so the youngest match overwrites; the output register ranks below all.
    logic [PW-1:0] scan_idx;

    always_comb begin
        lk_hit1  = 1'b0;
        lk_data1 = '0;
        lk_hit2  = 1'b0;
        lk_data2 = '0;
        scan_idx = '0;

        if (rf_we_q && (rf_waddr_q == lk_addr1)) begin
            lk_hit1  = 1'b1;
            lk_data1 = rf_wdata_q;
        end
        if (rf_we_q && (rf_waddr_q == lk_addr2)) begin
            lk_hit2  = 1'b1;
            lk_data2 = rf_wdata_q;
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (mem_addr[scan_idx] == lk_addr1) begin
                    lk_hit1  = 1'b1;
                    lk_data1 = mem_data[scan_idx];
                end
                if (mem_addr[scan_idx] == lk_addr2) begin
                    lk_hit2  = 1'b1;
                    lk_data2 = mem_data[scan_idx];
                end
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign count    = count_q;
    assign empty    = (count_q == '0) && !rf_we_q;

endmodule
